multicycle_controller: RTL

//  Multi-cycle sequencer for the MIPS CPU: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle sequencer for the MIPS CPU.
//
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives
// per-state strobes to the shared datapath (PC, IR, regfile, ALU operand
// mux, unified memory). Waits in FETCH and MEM until mem_ready. Counts
// retired instructions.
//
// Parameters:
//   CNT_W            width of the retired-instruction counter (wraps silently)
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   opcode           IR[31:26], valid from DECODE onward
//   function_opcode  IR[5:0]
//   zero             ALU zero flag, sampled in EXEC
//   mem_ready        memory completes the current request this cycle
//   mem_req          memory request, held until mem_ready
//   mem_write        request is a write (valid with mem_req)
//   i_or_d           0 = address from PC, 1 = from ALU result
//   ir_write         load IR
//   pc_write         load PC
//   pc_source        0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs (jr)
//   alu_src_b        1 = immediate operand
//   reg_write        regfile write strobe
//   wb_sel           0 = ALU, 1 = memory data, 2 = PC (jal)
//   state            current state (debug)
//   retire           one-cycle pulse when an instruction completes
//   instr_count      retired-instruction count
//   halted           in TRAP (ILLEGAL_TRAP_EN builds only, else constant 0)
//
// Configuration macro:
//   ILLEGAL_TRAP_EN  unknown encodings enter TRAP (halted until reset);
//                    when undefined they retire as NOPs.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       function_opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             alu_src_b,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   instr_count_q;

    logic is_j, is_jal, is_jr, is_branch, is_mem, is_alu_r, is_alu_i, goes_exec;

    // Instruction class decode from the IR fields.
    always_comb begin
        is_alu_r = 1'b0;
        if (opcode == OpRtype) begin
            case (function_opcode)
                6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23,
                6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: is_alu_r = 1'b1;
                default:                                  is_alu_r = 1'b0;
            endcase
        end
        is_j      = (opcode == OpJ);
        is_jal    = (opcode == OpJal);
        is_jr     = (opcode == OpRtype) && (function_opcode == FnJr);
        is_branch = (opcode == OpBeq) || (opcode == OpBne);
        is_mem    = (opcode == OpLw) || (opcode == OpSw);
        is_alu_i  = (opcode[5:3] == 3'b001);
        goes_exec = is_branch || is_mem || is_alu_r || is_alu_i;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_source = 2'd0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                if (is_j || is_jal) begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                if (is_jal) begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd2;
                end
                if (is_jr) begin
                    pc_write  = 1'b1;
                    pc_source = 2'd3;
                end
                if (is_j || is_jal || is_jr) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (goes_exec) begin
                    state_d = StExec;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = StTrap;
`else
                    // Unknown encoding: retire as a NOP with no writes.
                    retire  = 1'b1;
                    state_d = StFetch;
`endif
                end
            end
            StExec: begin
                if (is_branch) begin
                    pc_source = 2'd1;
                    pc_write  = (opcode == OpBne) ? ~zero : zero;
                    retire    = 1'b1;
                    state_d   = StFetch;
                end else if (is_mem) begin
                    alu_src_b = 1'b1;
                    state_d   = StMem;
                end else begin
                    alu_src_b = (opcode != OpRtype);
                    state_d   = StWb;
                end
            end
            StMem: begin
                // Request fields depend only on the held IR, so they stay
                // stable while waiting on mem_ready.
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = (opcode == OpSw);
                if (mem_ready) begin
                    if (opcode == OpSw) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                reg_write = 1'b1;
                wb_sel    = (opcode == OpLw) ? 2'd1 : 2'd0;
                retire    = 1'b1;
                state_d   = StFetch;
            end
`ifdef ILLEGAL_TRAP_EN
            StTrap: begin
                halted = 1'b1;
            end
`endif
            default: state_d = StFetch;
        endcase

        // Reset kills every strobe combinationally so a request in flight
        // never sees a partial write.
        if (reset) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            i_or_d    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_source = 2'd0;
            alu_src_b = 1'b0;
            reg_write = 1'b0;
            wb_sel    = 2'd0;
            retire    = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StFetch;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule
